// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, ERR} arb_state_t;

  localparam int unsigned DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter. master = arbiter, slave = its environment.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              IReqF;
  logic [ADDR_W-1:0] PCF;
  logic [DATA_W-1:0] InstrF;
  logic              IReadyF;
  logic              DReqM;
  logic              DWriteM;
  logic [ADDR_W-1:0] DAdrM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ReadDataM;
  logic              DReadyM;
  logic              MemStall;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAdr;
  logic [DATA_W-1:0] MemWD;
  logic [DATA_W-1:0] MemRD;
  logic              MemAck;
  logic              BusErr;

  modport master (
    input  IReqF, PCF, DReqM, DWriteM, DAdrM, WriteDataM, MemRD, MemAck,
    output InstrF, IReadyF, ReadDataM, DReadyM, MemStall, MemReq, MemWe, MemAdr, MemWD, BusErr
  );

  modport slave (
    output IReqF, PCF, DReqM, DWriteM, DAdrM, WriteDataM, MemRD, MemAck,
    input  InstrF, IReadyF, ReadDataM, DReadyM, MemStall, MemReq, MemWe, MemAdr, MemWD, BusErr
  );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait-state counter for one bus transaction; expire flags that MAX_WAIT wait cycles have elapsed.
module wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire = (count_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store, data first, with a sticky
// timeout error. Stale fetch results (PC redirected or request dropped) are discarded.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              iready_q, iready_d;
  logic              dready_q, dready_d;
  logic              tmr_clear, tmr_enable, tmr_expire;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wd_d       = wd_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    iready_d   = 1'b0;
    dready_d   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.DReqM) begin
          state_d   = DBUS;
          req_d     = 1'b1;
          we_d      = bus.DWriteM;
          adr_d     = bus.DAdrM;
          wd_d      = bus.WriteDataM;
          tmr_clear = 1'b1;
        end else if (bus.IReqF) begin
          state_d   = IBUS;
          req_d     = 1'b1;
          we_d      = 1'b0;
          adr_d     = bus.PCF;
          wd_d      = bus.WriteDataM;
          tmr_clear = 1'b1;
        end
      end
      IBUS, DBUS: begin
        if (bus.MemAck) begin
          // Ack beats a simultaneous timeout; the result is delivered only if still wanted.
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (state_q == DBUS) begin
            if (bus.DReqM) begin
              dready_d = 1'b1;
              if (!we_q) rdata_d = bus.MemRD;
            end
          end else if (bus.IReqF && (bus.PCF == adr_q)) begin
            iready_d = 1'b1;
            instr_d  = bus.MemRD;
          end
        end else if (tmr_expire) begin
          state_d = ERR;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wd_q     <= wd_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
    end
  end

  assign bus.MemReq    = req_q;
  assign bus.MemWe     = we_q;
  assign bus.MemAdr    = adr_q;
  assign bus.MemWD     = wd_q;
  assign bus.InstrF    = instr_q;
  assign bus.ReadDataM = rdata_q;
  assign bus.IReadyF   = iready_q;
  assign bus.DReadyM   = dready_q;
  assign bus.BusErr    = (state_q == ERR);
  assign bus.MemStall  = bus.DReqM & ~dready_q;

endmodule
